// File: rtl/poly_taps_loader.sv
// poly_taps_loader
// Initiator of the polynomial estimator tap-programming stream. Holds a
// host-writable shadow bank of single-precision taps. On a load command it
// drops the estimator enable for two cycles, streams the taps in index order
// over valid/ready, then waits a bounded time for the estimator done flag.
module poly_taps_loader #(
    parameter int unsigned G_POLY_ORDER   = 5,
    parameter int unsigned G_DONE_TIMEOUT = 1024,
    localparam int unsigned C_FP_DWIDTH   = 32
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   cfg_wr_en,
    input  logic [7:0]             cfg_wr_addr,
    input  logic [C_FP_DWIDTH-1:0] cfg_wr_data,
    output logic                   cfg_wr_err,
    input  logic                   load_start,
    output logic                   busy,
    output logic                   load_ok,
    output logic                   load_err,
    output logic                   est_enable,
    output logic [C_FP_DWIDTH-1:0] taps_prog_dout,
    output logic                   taps_prog_dout_valid,
    input  logic                   taps_prog_dout_ready,
    input  logic                   taps_prog_done
);

    // Index width sized so every index value addresses a real bank slot;
    // slots at or above G_POLY_ORDER are never written and stay zero.
    localparam int unsigned C_IDX_W      = (G_POLY_ORDER > 1) ? $clog2(G_POLY_ORDER) : 1;
    localparam int unsigned C_BANK_DEPTH = 1 << C_IDX_W;
    localparam int unsigned C_TMO_W      = $clog2(G_DONE_TIMEOUT + 1);

    localparam logic [C_IDX_W-1:0] C_LAST_IDX = C_IDX_W'(G_POLY_ORDER - 1);
    localparam logic [C_TMO_W-1:0] C_TMO_LAST = C_TMO_W'(G_DONE_TIMEOUT - 1);
    localparam logic [7:0]         C_ORDER_8  = 8'(G_POLY_ORDER);
    // DISABLE lasts for (C_DIS_LOAD + 1) cycles.
    localparam logic [1:0]         C_DIS_LOAD = 2'd1;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_DISABLE   = 3'd1,
        ST_STREAM    = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_OK        = 3'd4,
        ST_ERR       = 3'd5
    } state_t;

    state_t                   state_r;
    state_t                   state_nxt_s;

    logic [C_FP_DWIDTH-1:0]   bank_r [C_BANK_DEPTH];

    logic [C_IDX_W-1:0]       idx_r;
    logic [C_IDX_W-1:0]       idx_nxt_s;
    logic [C_IDX_W-1:0]       idx_inc_s;
    logic [1:0]               dis_cnt_r;
    logic [1:0]               dis_cnt_nxt_s;
    logic [C_TMO_W-1:0]       tmo_cnt_r;
    logic [C_TMO_W-1:0]       tmo_cnt_nxt_s;

    logic                     busy_r;
    logic                     busy_nxt_s;
    logic                     ok_r;
    logic                     ok_nxt_s;
    logic                     err_r;
    logic                     err_nxt_s;
    logic                     en_r;
    logic                     en_nxt_s;
    logic                     valid_r;
    logic                     valid_nxt_s;
    logic [C_FP_DWIDTH-1:0]   dout_r;
    logic [C_FP_DWIDTH-1:0]   dout_nxt_s;
    logic                     wr_err_r;

    logic                     idle_like_s;
    logic                     start_s;
    logic                     xfer_s;
    logic                     wr_ok_s;

    // The bank is writable and a load may start only while no load is in flight.
    assign idle_like_s = (state_r == ST_IDLE) || (state_r == ST_OK) || (state_r == ST_ERR);
    assign start_s     = load_start && idle_like_s;
    assign xfer_s      = valid_r && taps_prog_dout_ready;
    assign wr_ok_s     = cfg_wr_en && idle_like_s && (cfg_wr_addr < C_ORDER_8);
    assign idx_inc_s   = idx_r + C_IDX_W'(1);

    assign cfg_wr_err           = wr_err_r;
    assign busy                 = busy_r;
    assign load_ok              = ok_r;
    assign load_err             = err_r;
    assign est_enable           = en_r;
    assign taps_prog_dout       = dout_r;
    assign taps_prog_dout_valid = valid_r;

    // Shadow bank update and one-cycle rejection pulse for refused writes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(C_BANK_DEPTH); i++) begin
                bank_r[i] <= {C_FP_DWIDTH{1'b0}};
            end
            wr_err_r <= 1'b0;
        end else begin
            if (wr_ok_s) begin
                bank_r[cfg_wr_addr[C_IDX_W-1:0]] <= cfg_wr_data;
            end
            wr_err_r <= cfg_wr_en && !wr_ok_s;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE, ST_OK, ST_ERR: begin
                if (start_s) begin
                    state_nxt_s = ST_DISABLE;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_DISABLE: begin
                if (dis_cnt_r == 2'd0) begin
                    state_nxt_s = ST_STREAM;
                end else begin
                    state_nxt_s = ST_DISABLE;
                end
            end
            ST_STREAM: begin
                if (xfer_s && (idx_r == C_LAST_IDX)) begin
                    state_nxt_s = ST_WAIT_DONE;
                end else begin
                    state_nxt_s = ST_STREAM;
                end
            end
            ST_WAIT_DONE: begin
                // Done wins over a timeout landing on the same cycle.
                if (taps_prog_done) begin
                    state_nxt_s = ST_OK;
                end else if (tmo_cnt_r == C_TMO_LAST) begin
                    state_nxt_s = ST_ERR;
                end else begin
                    state_nxt_s = ST_WAIT_DONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FSM output decode: next values of the registered outputs and counters.
    always_comb begin
        idx_nxt_s     = idx_r;
        dis_cnt_nxt_s = dis_cnt_r;
        tmo_cnt_nxt_s = tmo_cnt_r;
        busy_nxt_s    = busy_r;
        ok_nxt_s      = ok_r;
        err_nxt_s     = err_r;
        en_nxt_s      = en_r;
        valid_nxt_s   = valid_r;
        dout_nxt_s    = dout_r;
        case (state_r)
            ST_IDLE, ST_OK, ST_ERR: begin
                if (start_s) begin
                    busy_nxt_s    = 1'b1;
                    ok_nxt_s      = 1'b0;
                    err_nxt_s     = 1'b0;
                    en_nxt_s      = 1'b0;
                    dis_cnt_nxt_s = C_DIS_LOAD;
                    idx_nxt_s     = {C_IDX_W{1'b0}};
                end else begin
                    busy_nxt_s    = 1'b0;
                end
            end
            ST_DISABLE: begin
                if (dis_cnt_r == 2'd0) begin
                    // Enable and first word appear together.
                    en_nxt_s    = 1'b1;
                    valid_nxt_s = 1'b1;
                    dout_nxt_s  = bank_r[0];
                end else begin
                    dis_cnt_nxt_s = dis_cnt_r - 2'd1;
                end
            end
            ST_STREAM: begin
                if (xfer_s) begin
                    if (idx_r == C_LAST_IDX) begin
                        valid_nxt_s   = 1'b0;
                        tmo_cnt_nxt_s = {C_TMO_W{1'b0}};
                    end else begin
                        idx_nxt_s  = idx_inc_s;
                        dout_nxt_s = bank_r[idx_inc_s];
                    end
                end else begin
                    // Word is held until the estimator accepts it.
                    valid_nxt_s = valid_r;
                end
            end
            ST_WAIT_DONE: begin
                if (taps_prog_done) begin
                    ok_nxt_s   = 1'b1;
                    busy_nxt_s = 1'b0;
                end else if (tmo_cnt_r == C_TMO_LAST) begin
                    err_nxt_s  = 1'b1;
                    busy_nxt_s = 1'b0;
                    en_nxt_s   = 1'b0;
                end else begin
                    tmo_cnt_nxt_s = tmo_cnt_r + C_TMO_W'(1);
                end
            end
            default: begin
                idx_nxt_s     = {C_IDX_W{1'b0}};
                dis_cnt_nxt_s = 2'd0;
                tmo_cnt_nxt_s = {C_TMO_W{1'b0}};
                busy_nxt_s    = 1'b0;
                ok_nxt_s      = 1'b0;
                err_nxt_s     = 1'b0;
                en_nxt_s      = 1'b0;
                valid_nxt_s   = 1'b0;
                dout_nxt_s    = {C_FP_DWIDTH{1'b0}};
            end
        endcase
    end

    // Registered outputs, tap index and the disable/timeout counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx_r     <= {C_IDX_W{1'b0}};
            dis_cnt_r <= 2'd0;
            tmo_cnt_r <= {C_TMO_W{1'b0}};
            busy_r    <= 1'b0;
            ok_r      <= 1'b0;
            err_r     <= 1'b0;
            en_r      <= 1'b0;
            valid_r   <= 1'b0;
            dout_r    <= {C_FP_DWIDTH{1'b0}};
        end else begin
            idx_r     <= idx_nxt_s;
            dis_cnt_r <= dis_cnt_nxt_s;
            tmo_cnt_r <= tmo_cnt_nxt_s;
            busy_r    <= busy_nxt_s;
            ok_r      <= ok_nxt_s;
            err_r     <= err_nxt_s;
            en_r      <= en_nxt_s;
            valid_r   <= valid_nxt_s;
            dout_r    <= dout_nxt_s;
        end
    end

endmodule

// File: tb/tb_poly_taps_loader.sv
// Testbench for poly_taps_loader: expected tap beats are queued when a load
// is issued and a negedge monitor pops and compares each transfer; status
// flags are checked against hand-derived cycle timing.
module tb_poly_taps_loader;

    localparam int unsigned TB_ORDER = 5;
    localparam int unsigned TB_TMO   = 8;

    logic        clk;
    logic        reset_n;
    logic        cfg_wr_en;
    logic [7:0]  cfg_wr_addr;
    logic [31:0] cfg_wr_data;
    logic        cfg_wr_err;
    logic        load_start;
    logic        busy;
    logic        load_ok;
    logic        load_err;
    logic        est_enable;
    logic [31:0] taps_prog_dout;
    logic        taps_prog_dout_valid;
    logic        taps_prog_dout_ready;
    logic        taps_prog_done;

    poly_taps_loader #(
        .G_POLY_ORDER   (TB_ORDER),
        .G_DONE_TIMEOUT (TB_TMO)
    ) dut (
        .clk                  (clk),
        .reset_n              (reset_n),
        .cfg_wr_en            (cfg_wr_en),
        .cfg_wr_addr          (cfg_wr_addr),
        .cfg_wr_data          (cfg_wr_data),
        .cfg_wr_err           (cfg_wr_err),
        .load_start           (load_start),
        .busy                 (busy),
        .load_ok              (load_ok),
        .load_err             (load_err),
        .est_enable           (est_enable),
        .taps_prog_dout       (taps_prog_dout),
        .taps_prog_dout_valid (taps_prog_dout_valid),
        .taps_prog_dout_ready (taps_prog_dout_ready),
        .taps_prog_done       (taps_prog_done)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_beats  = 0;

    logic [31:0] exp_q[$];
    logic [31:0] model[TB_ORDER];

    logic        held      = 1'b0;
    logic [31:0] held_data = 32'd0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        check(name, {31'd0, act}, {31'd0, exp});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every transfer must match the head of the queue, and a word
    // offered without ready must still be offered, unchanged, next cycle.
    always @(negedge clk) begin
        if (!reset_n) begin
            held = 1'b0;
        end else begin
            if (held) begin
                check1("hold_valid", taps_prog_dout_valid, 1'b1);
                check("hold_data", taps_prog_dout, held_data);
            end
            if (taps_prog_dout_valid && taps_prog_dout_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", taps_prog_dout, 32'hFFFF_FFFF);
                end else begin
                    check("beat_data", taps_prog_dout, exp_q.pop_front());
                end
                n_beats++;
                held = 1'b0;
            end else if (taps_prog_dout_valid) begin
                held      = 1'b1;
                held_data = taps_prog_dout;
            end else begin
                held = 1'b0;
            end
        end
    end

    task automatic wr(input logic [7:0] addr, input logic [31:0] data);
        cfg_wr_en   = 1'b1;
        cfg_wr_addr = addr;
        cfg_wr_data = data;
        tick();
        cfg_wr_en   = 1'b0;
    endtask

    task automatic start_load();
        for (int i = 0; i < int'(TB_ORDER); i++) exp_q.push_back(model[i]);
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    task automatic wait_stream(input string name);
        logic seen;
        seen = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (exp_q.size() == 0 && !taps_prog_dout_valid) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        check1(name, seen, 1'b1);
    endtask

    task automatic finish_ok(input string name);
        taps_prog_done = 1'b1;
        tick();
        taps_prog_done = 1'b0;
        check1({name, "_ok"}, load_ok, 1'b1);
        check1({name, "_busy"}, busy, 1'b0);
        check1({name, "_en"}, est_enable, 1'b1);
    endtask

    logic [31:0] def_taps[TB_ORDER];
    logic        bp_pat[6];

    initial begin
        def_taps = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000, 32'h40A0_0000};
        bp_pat   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        reset_n = 1'b0; cfg_wr_en = 1'b0; cfg_wr_addr = 8'd0; cfg_wr_data = 32'd0;
        load_start = 1'b0; taps_prog_dout_ready = 1'b1; taps_prog_done = 1'b0;
        for (int i = 0; i < int'(TB_ORDER); i++) model[i] = 32'd0;
        #1;
        // Reset state
        check1("rst_busy", busy, 1'b0);
        check1("rst_ok", load_ok, 1'b0);
        check1("rst_err", load_err, 1'b0);
        check1("rst_en", est_enable, 1'b0);
        check1("rst_valid", taps_prog_dout_valid, 1'b0);
        check("rst_dout", taps_prog_dout, 32'd0);
        check1("rst_wrerr", cfg_wr_err, 1'b0);
        repeat (2) tick();
        reset_n = 1'b1;
        tick();

        // 1: default taps, ready tied high
        for (int i = 0; i < int'(TB_ORDER); i++) begin
            wr(8'(i), def_taps[i]);
            model[i] = def_taps[i];
        end
        check1("good_wr_noerr", cfg_wr_err, 1'b0);
        start_load();                                     // cycle T+1
        check1("t1_busy", busy, 1'b1);
        check1("t1_en_t1", est_enable, 1'b0);
        tick();                                           // T+2
        check1("t1_en_t2", est_enable, 1'b0);
        check1("t1_valid_t2", taps_prog_dout_valid, 1'b0);
        tick();                                           // T+3
        check1("t1_en_t3", est_enable, 1'b1);
        check1("t1_valid_t3", taps_prog_dout_valid, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check1("t1_valid_run", taps_prog_dout_valid, 1'b1);
        end
        tick();                                           // T+8
        check1("t1_valid_end", taps_prog_dout_valid, 1'b0);
        check("t1_beats_left", 32'(exp_q.size()), 32'd0);
        finish_ok("t1");

        // 2: backpressure, with tap 3 changed to -1.0
        wr(8'd3, 32'hBF80_0000);
        model[3] = 32'hBF80_0000;
        n_beats = 0;
        start_load();
        begin
            logic done_seen;
            done_seen = 1'b0;
            for (int c = 0; c < 100; c++) begin
                if (c > 2 && exp_q.size() == 0 && !taps_prog_dout_valid) begin
                    done_seen = 1'b1;
                    break;
                end
                taps_prog_dout_ready = bp_pat[c % 6];
                tick();
            end
            check1("t2_stream_end", done_seen, 1'b1);
        end
        taps_prog_dout_ready = 1'b1;
        check("t2_beat_count", 32'(n_beats), 32'd5);
        finish_ok("t2");

        // 3: timeout after the last beat
        start_load();
        wait_stream("t3_stream_end");                     // first WAIT_DONE cycle
        repeat (7) tick();
        check1("t3_err_early", load_err, 1'b0);
        check1("t3_busy_early", busy, 1'b1);
        tick();
        check1("t3_err", load_err, 1'b1);
        check1("t3_en", est_enable, 1'b0);
        check1("t3_busy", busy, 1'b0);
        check1("t3_ok", load_ok, 1'b0);
        start_load();
        check1("t3_err_cleared", load_err, 1'b0);
        // 4a: write while busy is rejected
        wr(8'd2, 32'hDEAD_BEEF);
        check1("t4_busy_wrerr", cfg_wr_err, 1'b1);
        tick();
        check1("t4_busy_wrerr_off", cfg_wr_err, 1'b0);
        wait_stream("t4_stream1_end");
        finish_ok("t4a");
        // 4b: out-of-range write while idle is rejected
        wr(8'd7, 32'h1234_5678);
        check1("t4_addr_wrerr", cfg_wr_err, 1'b1);
        tick();
        check1("t4_addr_wrerr_off", cfg_wr_err, 1'b0);
        start_load();
        wait_stream("t4_stream2_end");
        finish_ok("t4b");

        // 5: reset after the second beat
        start_load();
        repeat (4) tick();                                // two beats transferred
        reset_n = 1'b0;
        #1;
        check1("t5_valid", taps_prog_dout_valid, 1'b0);
        check1("t5_en", est_enable, 1'b0);
        check1("t5_busy", busy, 1'b0);
        check1("t5_ok", load_ok, 1'b0);
        check("t5_dout", taps_prog_dout, 32'd0);
        exp_q.delete();
        for (int i = 0; i < int'(TB_ORDER); i++) model[i] = 32'd0;
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
        start_load();
        wait_stream("t5_stream_end");
        finish_ok("t5");

        // 6: write and load_start in the same cycle
        cfg_wr_en   = 1'b1;
        cfg_wr_addr = 8'd0;
        cfg_wr_data = 32'hC000_0000;
        model[0]    = 32'hC000_0000;
        start_load();
        cfg_wr_en   = 1'b0;
        check1("t6_wrerr", cfg_wr_err, 1'b0);
        wait_stream("t6_stream_end");
        finish_ok("t6");

        repeat (2) tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/poly_taps_loader.md
Name: poly_taps_loader

Overview:
- Initiator side of the polynomial estimator's tap-programming stream.
- Holds a host-writable shadow bank of G_POLY_ORDER IEEE-754 single-precision taps.
- On command it restarts the estimator by dropping its enable, streams the taps in order over a valid/ready handshake, then waits for the estimator's programming-done flag.
- It reports success, or a timeout error, to the control plane.

Parameters:
- G_POLY_ORDER, 5: number of taps streamed, 1..255; tap index 0 is the constant term.
- G_DONE_TIMEOUT, 1024: cycles allowed in WAIT_DONE before declaring an error, ≥1.
- C_FP_DWIDTH, 32 (localparam): float word width.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- cfg_wr_en  in  1  shadow-bank write strobe
- cfg_wr_addr  in  8  tap index
- cfg_wr_data  in  32  tap value (float)
- cfg_wr_err  out  1  one-cycle pulse: write rejected
- load_start  in  1  one-cycle command to (re)program the estimator
- busy  out  1  high from accepted load_start until OK or ERR
- load_ok  out  1  sticky success, cleared by the next accepted load_start
- load_err  out  1  sticky timeout, cleared by the next accepted load_start
- est_enable  out  1  drives the estimator enable
- taps_prog_dout  out  32  tap word to the estimator
- taps_prog_dout_valid  out  1  tap word valid
- taps_prog_dout_ready  in  1  estimator ready
- taps_prog_done  in  1  estimator programming complete (level)

Behaviour:
- Reset (async assert, sync deassert):
  - All outputs are 0, including est_enable, dout and valid.
  - All bank entries are 0.
  - State is IDLE, all counters are 0.
  - Reset asserted mid-stream aborts immediately; no partial status is retained.
- Bank writes:
  - A write is accepted when cfg_wr_en=1, state is IDLE, OK or ERR, and cfg_wr_addr < G_POLY_ORDER. The entry updates on that edge.
  - Otherwise (busy, or address out of range) the bank is unchanged and cfg_wr_err pulses high for exactly one cycle, on the cycle after the strobe.
  - A write and load_start in the same cycle: the write is applied, and the stream carries the new value.
- States: IDLE, DISABLE, STREAM, WAIT_DONE, OK, ERR.
  - IDLE/OK/ERR → DISABLE on load_start=1. On that edge: busy=1, load_ok=0, load_err=0, est_enable=0, a 2-bit counter is loaded, and tap index idx=0.
  - DISABLE holds est_enable=0 for exactly 2 cycles, which forces the estimator back to its init state. Then → STREAM.
  - STREAM is entered by an edge that sets est_enable=1, taps_prog_dout=bank[0] and taps_prog_dout_valid=1 together.
  - For a load_start at edge T: est_enable is low during cycles T+1 and T+2; est_enable and valid are high from cycle T+3.
  - load_start while busy is ignored, with no error.
- STREAM handshake rules:
  - A beat transfers on valid & ready at a rising edge.
  - valid never drops and dout never changes without a transfer.
  - After a transfer, if idx < G_POLY_ORDER-1: idx++, dout=bank[idx+1], valid stays 1. Back-to-back beats sustain 1 word/cycle.
  - After the transfer of idx = G_POLY_ORDER-1: valid=0 and → WAIT_DONE with the timeout counter cleared.
  - taps_prog_done is ignored outside WAIT_DONE, because stale done is cleared while the estimator is disabled.
- WAIT_DONE:
  - If taps_prog_done=1 is sampled → OK: load_ok=1, busy=0, est_enable stays 1. The estimator is left running.
  - Otherwise the counter increments. When it reaches G_DONE_TIMEOUT with done still 0 → ERR: load_err=1, busy=0, est_enable=0.
  - Done arriving on the same cycle as the timeout counts as success.
- OK/ERR hold their state, and est_enable keeps its value, until the next load_start or reset.
- Bank data is never modified by streaming. Re-loading resends the same values.

Test Plan:
- Default taps: write bank = {0x3F800000, 0x40000000, 0x40400000, 0x40800000, 0x40A00000}, pulse load_start with ready tied 1.
  → est_enable low 2 cycles; 5 beats on consecutive cycles in index order; valid low after the 5th; done asserted 1 cycle later → load_ok=1, busy=0, est_enable=1.
- Backpressure: ready toggles 1,0,0,1,0,1,…
  → each word is held stable while valid and ready=0; exactly 5 transfers in order with no duplicates or skips.
- Timeout: G_DONE_TIMEOUT=8, done held 0 after the last beat.
  → load_err=1 exactly 8 cycles after entering WAIT_DONE; est_enable=0; busy=0. A following load_start clears load_err.
- Rejected writes: write addr 2 while busy, and write addr 7 while idle.
  → cfg_wr_err pulses once per write; a re-load streams the unchanged values.
- Reset mid-stream: assert reset_n low after the 2nd beat.
  → outputs go to 0 asynchronously; after release, a reload streams zeros, proving the bank was cleared.
- Same-cycle write and start: write addr 0 = 0xC0000000 together with load_start.
  → the first beat carries 0xC0000000.
